// File: rtl/aes_pkg.sv
// Shared AES definitions for the cipher datapath.
//   ciph_op_e       : cipher direction (forward / inverse)
//   sub_bytes_sts_e : state of the serial SubBytes unit
//   gf_mul / gf_inv : GF(2^8) arithmetic over x^8+x^4+x^3+x+1
//   sbox_affine / sbox_inv_affine : S-box affine map and its inverse
package aes_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } ciph_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_bytes_sts_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and 0 maps to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = a;
    for (int unsigned i = 0; i < 7; i++) begin
      x = gf_mul(x, x);
      r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_affine(input logic [7:0] x);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^
           {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

endpackage

// File: rtl/aes_sbox_canright.sv
// Combinational AES S-box lane, forward or inverse.
//   op_i   : CIPH_FWD -> S-box, CIPH_INV -> inverse S-box
//   data_i : input byte
//   data_o : substituted byte
module aes_sbox_canright
  import aes_pkg::*;
(
  input  ciph_op_e   op_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] pre_inv;
  logic [7:0] inv;

  // Both directions share one field inverter; only the affine map moves
  // from after the inversion (forward) to before it (inverse).
  always_comb begin
    pre_inv = (op_i == CIPH_INV) ? sbox_inv_affine(data_i) : data_i;
    inv     = gf_inv(pre_inv);
    data_o  = (op_i == CIPH_INV) ? inv : sbox_affine(inv);
  end

endmodule

// File: rtl/aes_sub_bytes_serial.sv
// Iterative SubBytes / InvSubBytes: NUM_SBOX S-box lanes process the
// 16-byte state NUM_SBOX bytes per cycle, writing results back in place.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   op_i                    : 0 SubBytes, 1 InvSubBytes (sampled at accept)
//   in_valid_i / in_ready_o : input handshake, data_i = state (byte k at [8k+:8])
//   out_valid_o/out_ready_i : output handshake, data_o = state register
module aes_sub_bytes_serial
  import aes_pkg::*;
#(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o
);

  localparam int unsigned L  = 16 / NUM_SBOX;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4 ||
        NUM_SBOX == 8 || NUM_SBOX == 16)) begin : g_bad_num_sbox
    $error("aes_sub_bytes_serial: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  sub_bytes_sts_e sts_q, sts_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   state_q, state_d;
  ciph_op_e       op_q, op_d;

  logic [7:0] lane_in  [NUM_SBOX];
  logic [7:0] lane_out [NUM_SBOX];

  always_comb begin
    for (int unsigned j = 0; j < NUM_SBOX; j++) begin
      lane_in[j] = state_q[8*(32'(cnt_q)*NUM_SBOX + j) +: 8];
    end
  end

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_lane
    aes_sbox_canright u_sbox (
      .op_i   (op_q),
      .data_i (lane_in[g]),
      .data_o (lane_out[g])
    );
  end

  always_comb begin
    sts_d   = sts_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    op_d    = op_q;
    case (sts_q)
      IDLE: begin
        if (in_valid_i) begin
          state_d = data_i;
          op_d    = ciph_op_e'(op_i);
          cnt_d   = '0;
          sts_d   = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned j = 0; j < NUM_SBOX; j++) begin
          state_d[8*(32'(cnt_q)*NUM_SBOX + j) +: 8] = lane_out[j];
        end
        if (cnt_q == CW'(L - 1)) begin
          cnt_d = '0;
          sts_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) sts_d = IDLE;
      end
      default: sts_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sts_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      op_q    <= CIPH_FWD;
    end else begin
      sts_q   <= sts_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Handshake outputs depend only on registered state; reset masks them so
  // nothing is offered or accepted while rst_i is high.
  assign in_ready_o  = (sts_q == IDLE) && !rst_i;
  assign out_valid_o = (sts_q == DONE) && !rst_i;
  assign data_o      = state_q;

endmodule
